// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the MEM stage and memory.
// The master holds request, address, lanes and store data until acknowledge.
interface mem_access_unit_if;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;

    modport master (
        output bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
        input  bus_read_data, bus_acknowledge
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
        output bus_read_data, bus_acknowledge
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the data bus and produces MEM/WB write-back fields.
// Latency: non-memory ops 0 cycles; memory ops 3 cycles minimum, +1 per extra ack wait cycle.
// Backpressure: stall_request holds upstream while a bus cycle is pending; stall[4] holds DONE.
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        stall,
    input  logic [7:0]        mem_operator,
    input  logic [31:0]       mem_operand_a,
    input  logic [31:0]       mem_operand_b,
    input  logic              mem_register_write_enable,
    input  logic [4:0]        mem_register_write_address,
    input  logic [31:0]       mem_register_write_data,
    output logic              wb_register_write_enable,
    output logic [4:0]        wb_register_write_address,
    output logic [31:0]       wb_register_write_data,
    output logic              stall_request,
    output logic              address_error,
    output logic              bus_error,
    mem_access_unit_if.master bus
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

    state_t       state;
    logic         req_q, write_q, bus_error_q;
    logic [31:0]  addr_q, wdata_q;
    logic [3:0]   bsel_q;
    logic [1:0]   cap_size, cap_off;
    logic         cap_signed, cap_wen;
    logic [4:0]   cap_waddr;
    logic [31:0]  cap_data;
    logic [CW-1:0] ack_count;

    logic         is_mem, is_load, is_signed, misaligned, issue, timeout_hit;
    logic [1:0]   size;
    logic [3:0]   lanes;
    logic [31:0]  store_data, load_value;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;

    // Only the MEM bit of the stall vector matters here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[3:0]};

    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b1;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (mem_operator)
            OP_LB:   begin size = SZ_BYTE; is_signed = 1'b1; end
            OP_LBU:  size = SZ_BYTE;
            OP_LH:   begin size = SZ_HALF; is_signed = 1'b1; end
            OP_LHU:  size = SZ_HALF;
            OP_LW:   size = SZ_WORD;
            OP_SB:   begin size = SZ_BYTE; is_load = 1'b0; end
            OP_SH:   begin size = SZ_HALF; is_load = 1'b0; end
            OP_SW:   is_load = 1'b0;
            default: begin is_mem = 1'b0; is_load = 1'b0; end
        endcase
    end

    assign misaligned = is_mem && (((size == SZ_HALF) && mem_operand_a[0]) ||
                                   ((size == SZ_WORD) && (mem_operand_a[1:0] != 2'b00)));
    assign issue = is_mem && !misaligned;

    // Big-endian lane mapping: address offset 0 is the most significant byte.
    always_comb begin
        lanes      = 4'b1111;
        store_data = 32'h0;
        case (size)
            SZ_BYTE: lanes = 4'b1000 >> mem_operand_a[1:0];
            SZ_HALF: lanes = mem_operand_a[1] ? 4'b0011 : 4'b1100;
            default: lanes = 4'b1111;
        endcase
        if (!is_load) begin
            case (size)
                SZ_BYTE: store_data = {4{mem_operand_b[7:0]}};
                SZ_HALF: store_data = {2{mem_operand_b[15:0]}};
                default: store_data = mem_operand_b;
            endcase
        end
    end

    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = cap_off[1] ? bus.bus_read_data[15:0] : bus.bus_read_data[31:16];
        load_value = bus.bus_read_data;
        case (cap_off)
            2'd0: byte_sel = bus.bus_read_data[31:24];
            2'd1: byte_sel = bus.bus_read_data[23:16];
            2'd2: byte_sel = bus.bus_read_data[15:8];
            default: byte_sel = bus.bus_read_data[7:0];
        endcase
        case (cap_size)
            SZ_BYTE: load_value = {{24{cap_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_value = {{16{cap_signed & half_sel[15]}}, half_sel};
            default: load_value = bus.bus_read_data;
        endcase
    end

    // The abort edge is the one at which the counter would reach ACK_TIMEOUT.
    assign timeout_hit = (ACK_TIMEOUT != 0) && ((int'(ack_count) + 1) >= ACK_TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            write_q     <= 1'b0;
            bus_error_q <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            bsel_q      <= 4'h0;
            cap_size    <= SZ_BYTE;
            cap_off     <= 2'b00;
            cap_signed  <= 1'b0;
            cap_wen     <= 1'b0;
            cap_waddr   <= 5'd0;
            cap_data    <= 32'h0;
            ack_count   <= '0;
        end else begin
            bus_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state      <= WAIT_ACK;
                        req_q      <= 1'b1;
                        write_q    <= !is_load;
                        addr_q     <= {mem_operand_a[31:2], 2'b00};
                        bsel_q     <= lanes;
                        wdata_q    <= store_data;
                        cap_size   <= size;
                        cap_off    <= mem_operand_a[1:0];
                        cap_signed <= is_signed;
                        cap_wen    <= is_load && mem_register_write_enable;
                        cap_waddr  <= mem_register_write_address;
                        ack_count  <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (bus.bus_acknowledge) begin
                        req_q    <= 1'b0;
                        cap_data <= load_value;
                        state    <= DONE;
                    end else if (timeout_hit) begin
                        req_q       <= 1'b0;
                        bus_error_q <= 1'b1;
                        cap_wen     <= 1'b0;
                        ack_count   <= ack_count + CW'(1);
                        state       <= DONE;
                    end else if (ACK_TIMEOUT != 0) begin
                        ack_count <= ack_count + CW'(1);
                    end
                end
                DONE: begin
                    if (!stall[4]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_request             = 1'b0;
        address_error             = 1'b0;
        wb_register_write_enable  = 1'b0;
        wb_register_write_address = mem_register_write_address;
        wb_register_write_data    = mem_register_write_data;
        case (state)
            IDLE: begin
                if (!is_mem)         wb_register_write_enable = mem_register_write_enable;
                else if (misaligned) address_error = 1'b1;
                else                 stall_request = 1'b1;
            end
            WAIT_ACK: stall_request = 1'b1;
            DONE: begin
                wb_register_write_enable  = cap_wen;
                wb_register_write_address = cap_waddr;
                wb_register_write_data    = cap_data;
            end
            default: ;
        endcase
        if (reset) begin
            stall_request = 1'b0;
            address_error = 1'b0;
        end
    end

    assign bus_error           = bus_error_q;
    assign bus.bus_request     = req_q;
    assign bus.bus_write       = write_q;
    assign bus.bus_address     = addr_q;
    assign bus.bus_byte_select = bsel_q;
    assign bus.bus_write_data  = wdata_q;

endmodule
